mandel_engine: RTL and testbench
================================

# mandel_engine

Single Mandelbrot iteration engine. It is the receiving end of the coordinate dispatcher's engine bus. It advertises availability on `done` and captures an 83-bit coordinate word when addressed. It iterates z ← z² + c in signed Q8.24 fixed point until escape or the iteration cap, then presents {x, y, iteration count} to the pixel writer over a valid/ack handshake. Four instances (ENGINE_ID 0–3) sit behind one dispatcher; their `done` outputs form the dispatcher's one-hot `cdones` bus.

## Interface
Parameters:
- `ENGINE_ID`, 0: engine address this instance responds to (0–3).
- `ITER_W`, 8: width of the iteration counter.
- `MAX_ITER`, 255: iteration cap; must be < 2**ITER_W.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `latch_en` in 1: dispatcher strobe; a word is on `word_in` for `engine_addr`.
- `engine_addr` in 3: target engine of the current strobe.
- `word_in` in 83: {x[82:73] (10b), y[72:64] (9b), cr[63:32], ci[31:0]}; cr/ci signed Q8.24.
- `done` out 1: engine idle and ready for a new word.
- `res_valid` out 1: result held on `res_*`.
- `res_ack` in 1: writer accepts the result.
- `res_x` out 10: captured pixel x.
- `res_y` out 9: captured pixel y.
- `res_iter` out ITER_W: iterations performed before escape, or MAX_ITER.

## Operation
- States: IDLE, ITER, RESULT.
- IDLE: `done`=1, `res_valid`=0.
  - Capture happens at the edge where `latch_en`=1 and `engine_addr`==ENGINE_ID.
  - On capture, load x, y, cr, ci; clear zr, zi and iter; go to ITER; `done` drops at that same edge.
- Strobes are ignored when the address mismatches or the state is not IDLE.
- ITER, one check per cycle on the current z:
  - sr = zr², si = zi² as full 64-bit signed products, taking bits [55:24].
  - mag = sr + si, computed 33 bits wide.
  - If mag > 0x04000000 (4.0), or iter == MAX_ITER: go to RESULT with `res_iter` = iter.
  - Otherwise: zr ← sr − si + cr; zi ← (2·zr·zi)[55:24] + ci; iter ← iter + 1.
- Width rule: |z| ≤ 2 whenever an update is taken, so all intermediate values fit Q8.24. No saturation logic.
- RESULT: `res_valid`=1, with `res_x`, `res_y` and `res_iter` stable. At the edge where `res_valid`&&`res_ack`, go to IDLE; `done`=1 and `res_valid`=0 the next cycle.
- `res_ack` while not in RESULT: ignored.
- Reset at any state: abandon the computation and go to IDLE.
  - `done`=1, `res_valid`=0.
  - `res_x`, `res_y`, `res_iter`, z and iter = 0.

## Timing
- Capture edge k: `done`=0 from k. The dispatcher samples `done` on negedge, so it never sees a stale 1 after capture.
- Escape after n updates: `res_valid` rises at edge k+n+1.
- Non-escaping point: `res_valid` rises at k+MAX_ITER+1, with `res_iter`=MAX_ITER.
- Ack on the edge where `res_valid` is first seen: `done` rises at the following edge. Minimum turnaround is 2 cycles in RESULT→IDLE→capture.
- Simultaneous strobe and ack in RESULT: the strobe is ignored; the dispatcher re-offers the word.
- `done` and `res_valid` are never both 1.

## Configuration
- Macro `MANDEL_BULB_SKIP_EN`:
  - Defined: the first ITER cycle also evaluates (cr+1)² + ci² < 0x00100000 (1/16, the period-2 bulb). If true, go to RESULT at k+1 with `res_iter`=MAX_ITER.
  - Undefined: no bulb test; points inside the bulb iterate to the cap.
- Result values are identical either way; only latency differs.

## Test plan
- Reset, then idle: `done`=1, `res_valid`=0, all `res_*`=0. A strobe with `engine_addr`≠ENGINE_ID leaves `done`=1.
- Escape case: capture x=5, y=7, cr=ci=0x01000000 (1+1i) at edge k.
  - Required: `res_valid` at k+3, `res_iter`=2, `res_x`=5, `res_y`=7.
- Interior case: capture cr=ci=0.
  - Required: `res_iter`=255 at k+256.
  - A second strobe during ITER is ignored.
- Bulb case: capture cr=0xFF000000 (−1), ci=0.
  - With MANDEL_BULB_SKIP_EN: `res_valid` at k+1 with `res_iter`=255.
  - Without the macro: `res_valid` at k+256 with `res_iter`=255.
- Handshake: hold `res_ack`=0 for 10 cycles; outputs stay stable and `done`=0. Pulse ack; `done`=1 on the next cycle.
- Reset asserted mid-ITER: `done`=1 and `res_valid`=0 after the reset edge. A new capture then completes normally.

Source files
------------

// File: rtl/mandel_engine.sv
// rtl/mandel_engine.sv - single Mandelbrot iteration engine, signed Q8.24, MANDEL_BULB_SKIP_EN enables period-2 bulb early exit
module mandel_engine #(
  parameter int ENGINE_ID = 0,
  parameter int ITER_W    = 8,
  parameter int MAX_ITER  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              latch_en,
  input  logic [2:0]        engine_addr,
  input  logic [82:0]       word_in,
  output logic              done,
  output logic              res_valid,
  input  logic              res_ack,
  output logic [9:0]        res_x,
  output logic [8:0]        res_y,
  output logic [ITER_W-1:0] res_iter
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_RESULT} state_t;

  state_t state, state_nxt;

  logic [9:0]         x_q;
  logic [8:0]         y_q;
  logic signed [31:0] cr_q, ci_q, zr_q, zi_q;
  logic [ITER_W-1:0]  iter_q, res_iter_q;

  logic signed [31:0] sr, si, zri2;
  logic signed [32:0] mag;
  logic               capture, escape, at_cap, bulb_hit, finish;

  // Squares and cross term of the current z, rescaled back to Q8.24
  assign sr   = 32'((64'(zr_q) * 64'(zr_q)) >>> 24);
  assign si   = 32'((64'(zi_q) * 64'(zi_q)) >>> 24);
  // Shifting the plain product by 23 instead of 24 folds in the factor of two
  assign zri2 = 32'((64'(zr_q) * 64'(zi_q)) >>> 23);
  assign mag  = 33'(sr) + 33'(si);

  assign capture = latch_en && (engine_addr == 3'(ENGINE_ID));
  assign escape  = mag > 33'sh0_0400_0000;
  assign at_cap  = iter_q == ITER_W'(MAX_ITER);

`ifdef MANDEL_BULB_SKIP_EN
  logic signed [31:0] br, br_sq, ci_sq;
  logic signed [32:0] bulb_mag;
  // Period-2 bulb: points within radius 1/4 of -1 never escape
  assign br       = cr_q + 32'sh0100_0000;
  assign br_sq    = 32'((64'(br) * 64'(br)) >>> 24);
  assign ci_sq    = 32'((64'(ci_q) * 64'(ci_q)) >>> 24);
  assign bulb_mag = 33'(br_sq) + 33'(ci_sq);
  // Only the first ITER cycle (iter still zero) is allowed to take the shortcut
  assign bulb_hit = (iter_q == '0) && (bulb_mag < 33'sh0_0010_0000);
`else
  assign bulb_hit = 1'b0;
`endif

  assign finish = escape || at_cap || bulb_hit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (capture) state_nxt = S_ITER;
      S_ITER:   if (finish)  state_nxt = S_RESULT;
      S_RESULT: if (res_ack) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    done      = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE:   done      = 1'b1;
      S_RESULT: res_valid = 1'b1;
      default: ;
    endcase
  end

  // Coordinate capture, z iteration and result latch
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      cr_q       <= '0;
      ci_q       <= '0;
      zr_q       <= '0;
      zi_q       <= '0;
      iter_q     <= '0;
      res_iter_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (capture) begin
            x_q    <= word_in[82:73];
            y_q    <= word_in[72:64];
            cr_q   <= word_in[63:32];
            ci_q   <= word_in[31:0];
            zr_q   <= '0;
            zi_q   <= '0;
            iter_q <= '0;
          end
        end
        S_ITER: begin
          if (finish) begin
            res_iter_q <= bulb_hit ? ITER_W'(MAX_ITER) : iter_q;
          end else begin
            zr_q   <= sr - si + cr_q;
            zi_q   <= zri2 + ci_q;
            iter_q <= iter_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_x    = x_q;
  assign res_y    = y_q;
  assign res_iter = res_iter_q;

endmodule

// File: tb/tb_mandel_engine.sv
// tb/tb_mandel_engine.sv - scoreboard bench for mandel_engine
module tb_mandel_engine;

  localparam int ID = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        latch_en;
  logic [2:0]  engine_addr;
  logic [82:0] word_in;
  logic        done;
  logic        res_valid;
  logic        res_ack;
  logic [9:0]  res_x;
  logic [8:0]  res_y;
  logic [7:0]  res_iter;

  mandel_engine #(.ENGINE_ID(ID), .ITER_W(8), .MAX_ITER(255)) dut (
    .clk(clk), .reset(reset), .latch_en(latch_en), .engine_addr(engine_addr),
    .word_in(word_in), .done(done), .res_valid(res_valid), .res_ack(res_ack),
    .res_x(res_x), .res_y(res_y), .res_iter(res_iter)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int it;
    int edge_n;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

`ifdef MANDEL_BULB_SKIP_EN
  localparam int BULB_LAT = 1;
`else
  localparam int BULB_LAT = 256;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Monitor: pops the scoreboard whenever res_valid rises
  task automatic monitor();
    logic pv = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && res_valid) begin
        tests++;
        fails++;
        $display("FAIL done_and_valid: both high at cycle %0d", cyc);
      end
      if (reset) begin
        pv = 1'b0;
      end else begin
        if (res_valid && !pv) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: x=%0d y=%0d iter=%0d", res_x, res_y, res_iter);
          end else begin
            e = q.pop_front();
            chk("res_x", 32'(res_x), 32'(e.x));
            chk("res_y", 32'(res_y), 32'(e.y));
            chk("res_iter", 32'(res_iter), 32'(e.it));
            chk("result_edge", 32'(cyc), 32'(e.edge_n));
          end
        end
        pv = res_valid;
      end
    end
  endtask

  // Strobe one word at the next edge; push expectation when a result is due
  task automatic capture(input int x, input int y, input logic [31:0] cr, input logic [31:0] ci,
                         input int it, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    latch_en    = 1'b1;
    engine_addr = 3'(ID);
    word_in     = {10'(x), 9'(y), cr, ci};
    @(posedge clk);
    #1;
    latch_en = 1'b0;
    if (push) begin
      e.x = x; e.y = y; e.it = it; e.edge_n = cyc + lat;
      q.push_back(e);
    end
    chk("done_low_after_capture", 32'(done), 32'd0);
  endtask

  task automatic wait_result();
    int n = 0;
    while (!res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: res_valid=%0d expected 1", res_valid);
    end
  endtask

  task automatic ack_result();
    @(negedge clk);
    res_ack = 1'b1;
    @(posedge clk);
    #1;
    res_ack = 1'b0;
    @(negedge clk);
    chk("done_after_ack", 32'(done), 32'd1);
    chk("valid_after_ack", 32'(res_valid), 32'd0);
  endtask

  initial begin
    logic [9:0] hx;
    logic [8:0] hy;
    logic [7:0] hi;
    reset = 1'b1; latch_en = 1'b0; engine_addr = '0; word_in = '0; res_ack = 1'b0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_x", 32'(res_x), 32'd0);
    chk("rst_y", 32'(res_y), 32'd0);
    chk("rst_iter", 32'(res_iter), 32'd0);

    // Strobe for another engine is ignored
    latch_en = 1'b1; engine_addr = 3'd1; word_in = {10'd9, 9'd9, 64'd0};
    @(posedge clk); #1; latch_en = 1'b0;
    chk("addr_mismatch_done", 32'(done), 32'd1);

    // Ack while idle is ignored
    res_ack = 1'b1;
    @(posedge clk); #1; res_ack = 1'b0;
    chk("idle_ack_done", 32'(done), 32'd1);

    // Escape: c = 1+1i, two updates then escape
    capture(5, 7, 32'h0100_0000, 32'h0100_0000, 2, 3, 1'b1);
    wait_result();
    hx = res_x; hy = res_y; hi = res_iter;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_x", 32'(res_x), 32'(hx));
      chk("hold_y", 32'(res_y), 32'(hy));
      chk("hold_iter", 32'(res_iter), 32'(hi));
      chk("hold_done", 32'(done), 32'd0);
      chk("hold_valid", 32'(res_valid), 32'd1);
    end
    ack_result();

    // Boundary: c = 2 gives mag exactly 4.0 (not an escape), then 36
    capture(9, 10, 32'h0200_0000, 32'h0000_0000, 2, 3, 1'b1);
    wait_result();
    ack_result();

    // Extreme coordinates, one update: c = 3
    capture(1023, 511, 32'h0300_0000, 32'h0000_0000, 1, 2, 1'b1);
    wait_result();
    // Strobe together with ack in RESULT is ignored
    @(negedge clk);
    res_ack = 1'b1; latch_en = 1'b1; engine_addr = 3'(ID); word_in = {10'd4, 9'd4, 64'd0};
    @(posedge clk); #1; res_ack = 1'b0; latch_en = 1'b0;
    @(negedge clk);
    chk("strobe_with_ack_done", 32'(done), 32'd1);
    chk("strobe_with_ack_valid", 32'(res_valid), 32'd0);

    // Interior point c = 0 runs to the cap; a mid-ITER strobe is ignored
    capture(1, 2, 32'h0, 32'h0, 255, 256, 1'b1);
    repeat (5) @(negedge clk);
    latch_en = 1'b1; engine_addr = 3'(ID); word_in = {10'd100, 9'd100, 32'h0300_0000, 32'h0};
    @(posedge clk); #1; latch_en = 1'b0;
    chk("iter_strobe_done", 32'(done), 32'd0);
    wait_result();
    ack_result();

    // c = -2 sits on the escape boundary forever and hits the cap
    capture(11, 12, 32'hFE00_0000, 32'h0, 255, 256, 1'b1);
    wait_result();
    ack_result();

    // Period-2 bulb, c = -1
    capture(3, 4, 32'hFF00_0000, 32'h0, 255, BULB_LAT, 1'b1);
    wait_result();
    ack_result();

    // Reset mid-ITER abandons the point
    capture(6, 6, 32'h0, 32'h0, 0, 0, 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_done", 32'(done), 32'd1);
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_x", 32'(res_x), 32'd0);
    chk("midrst_iter", 32'(res_iter), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // A fresh capture after reset completes normally
    capture(8, 3, 32'h0100_0000, 32'h0100_0000, 2, 3, 1'b1);
    wait_result();
    ack_result();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
